// File: rtl/udma_tx_credit_arbiter.sv
// Round-robin arbiter for the shared uDMA TX L2 read port, with a held grant and
// per-requester credit counters bounding outstanding reads.
module udma_tx_credit_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned S       = 2,
    parameter int unsigned MAX_OUT = 2,
    parameter int unsigned CW      = 2
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] grant_o,
    output logic         any_grant_o,
    output logic [S-1:0] grant_id_o,
    input  logic         grant_ack_i,
    input  logic         rsp_valid_i,
    input  logic [S-1:0] rsp_id_i,
    output logic [N-1:0] busy_o,
    output logic         idle_o,
    output logic         err_o
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [S-1:0]   gid_q, gid_d;
    logic [S-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]  cnt_q [N];
    logic [CW-1:0]  cnt_d [N];
    logic           err_q, err_d;

    logic [N-1:0]   elig;
    logic [N-1:0]   inc;
    logic [N-1:0]   dec;
    logic [N-1:0]   rot;
    logic           found;
    logic [S-1:0]   win;
    logic           ack_fire;

    assign ack_fire = (state_q == StGrant) && grant_ack_i;

    // Eligibility uses registered counts only; a same-cycle response never bypasses.
    always_comb begin
        int unsigned idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < N; i++) begin
            elig[i] = req_i[i] && (cnt_q[i] < CW'(MAX_OUT));
        end
        rot = N'({elig, elig} >> ptr_q);
        for (int k = 0; k < N; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                idx   = 32'(ptr_q) + 32'(k);
                if (idx >= N) idx = idx - N;
                win   = S'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gid_d   = gid_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StGrant;
                    grant_d = N'(1) << win;
                    gid_d   = win;
                end
            end
            StGrant: begin
                if (grant_ack_i) begin
                    state_d = StIdle;
                    grant_d = '0;
                    gid_d   = '0;
                    ptr_d   = (gid_q == S'(N - 1)) ? '0 : gid_q + S'(1);
                end else if (!(|(req_i & grant_q))) begin
                    state_d = StIdle;
                    grant_d = '0;
                    gid_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Illegal responses (out-of-range id or zero count) leave counts alone and flag err.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            inc[i]   = ack_fire && grant_q[i];
            dec[i]   = rsp_valid_i && (rsp_id_i == S'(i)) && (cnt_q[i] != '0);
            cnt_d[i] = cnt_q[i];
            if (inc[i] && !dec[i]) begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end else if (dec[i] && !inc[i]) begin
                cnt_d[i] = cnt_q[i] - CW'(1);
            end
        end
        err_d = rsp_valid_i && !(|dec);
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= StIdle;
            grant_q <= '0;
            gid_q   <= '0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gid_q   <= gid_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        idle_o = (state_q == StIdle);
        for (int i = 0; i < N; i++) begin
            busy_o[i] = (cnt_q[i] == CW'(MAX_OUT));
            if (cnt_q[i] != '0) idle_o = 1'b0;
        end
    end

    assign grant_o     = grant_q;
    assign any_grant_o = |grant_q;
    assign grant_id_o  = gid_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_udma_tx_credit_arbiter.sv
// Directed bench for udma_tx_credit_arbiter: a 4-requester/2-credit instance and a
// 3-requester/1-credit instance sharing clock and reset.
module tb_udma_tx_credit_arbiter;

    logic       clk = 1'b0;
    logic       rstn;
    logic [3:0] req;
    logic       ack;
    logic       rsp_valid;
    logic [1:0] rsp_id;
    logic [3:0] grant;
    logic       any_grant;
    logic [1:0] grant_id;
    logic [3:0] busy;
    logic       idle;
    logic       err;

    logic [2:0] req3;
    logic       ack3;
    logic       rsp_valid3;
    logic [1:0] rsp_id3;
    logic [2:0] grant3;
    logic       any3;
    logic [1:0] gid3;
    logic [2:0] busy3;
    logic       idle3;
    logic       err3;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    udma_tx_credit_arbiter #(.N(4), .S(2), .MAX_OUT(2), .CW(2)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .req_i       (req),
        .grant_o     (grant),
        .any_grant_o (any_grant),
        .grant_id_o  (grant_id),
        .grant_ack_i (ack),
        .rsp_valid_i (rsp_valid),
        .rsp_id_i    (rsp_id),
        .busy_o      (busy),
        .idle_o      (idle),
        .err_o       (err)
    );

    udma_tx_credit_arbiter #(.N(3), .S(2), .MAX_OUT(1), .CW(1)) dut3 (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .req_i       (req3),
        .grant_o     (grant3),
        .any_grant_o (any3),
        .grant_id_o  (gid3),
        .grant_ack_i (ack3),
        .rsp_valid_i (rsp_valid3),
        .rsp_id_i    (rsp_id3),
        .busy_o      (busy3),
        .idle_o      (idle3),
        .err_o       (err3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] oh_id(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) r = 2'(i);
        end
        return r;
    endfunction

    task automatic chk_g4(input string tag, input logic [3:0] exp_g);
        checks++;
        assert (grant === exp_g) passes++;
        else begin fails++; $error("FAIL %s grant_o: got %b expected %b", tag, grant, exp_g); end
        checks++;
        assert (any_grant === (|exp_g)) passes++;
        else begin fails++; $error("FAIL %s any_grant_o: got %b expected %b", tag, any_grant, |exp_g); end
        checks++;
        assert (grant_id === oh_id(exp_g)) passes++;
        else begin fails++; $error("FAIL %s grant_id_o: got %0d expected %0d", tag, grant_id, oh_id(exp_g)); end
    endtask

    task automatic chk_s4(input string tag, input logic [3:0] exp_busy, input logic exp_idle,
                          input logic exp_err);
        checks++;
        assert (busy === exp_busy) passes++;
        else begin fails++; $error("FAIL %s busy_o: got %b expected %b", tag, busy, exp_busy); end
        checks++;
        assert (idle === exp_idle) passes++;
        else begin fails++; $error("FAIL %s idle_o: got %b expected %b", tag, idle, exp_idle); end
        checks++;
        assert (err === exp_err) passes++;
        else begin fails++; $error("FAIL %s err_o: got %b expected %b", tag, err, exp_err); end
    endtask

    task automatic chk_g3(input string tag, input logic [2:0] exp_g);
        checks++;
        assert (grant3 === exp_g) passes++;
        else begin fails++; $error("FAIL %s grant_o: got %b expected %b", tag, grant3, exp_g); end
        checks++;
        assert (any3 === (|exp_g)) passes++;
        else begin fails++; $error("FAIL %s any_grant_o: got %b expected %b", tag, any3, |exp_g); end
        checks++;
        assert (gid3 === oh_id({1'b0, exp_g})) passes++;
        else begin fails++; $error("FAIL %s grant_id_o: got %0d expected %0d", tag, gid3, oh_id({1'b0, exp_g})); end
    endtask

    task automatic chk_s3(input string tag, input logic [2:0] exp_busy, input logic exp_idle,
                          input logic exp_err);
        checks++;
        assert (busy3 === exp_busy) passes++;
        else begin fails++; $error("FAIL %s busy_o: got %b expected %b", tag, busy3, exp_busy); end
        checks++;
        assert (idle3 === exp_idle) passes++;
        else begin fails++; $error("FAIL %s idle_o: got %b expected %b", tag, idle3, exp_idle); end
        checks++;
        assert (err3 === exp_err) passes++;
        else begin fails++; $error("FAIL %s err_o: got %b expected %b", tag, err3, exp_err); end
    endtask

    initial begin
        rstn = 1'b0; req = '0; ack = 1'b0; rsp_valid = 1'b0; rsp_id = '0;
        req3 = '0; ack3 = 1'b0; rsp_valid3 = 1'b0; rsp_id3 = '0;
        tick();
        tick();
        chk_g4("reset", 4'b0000);
        chk_s4("reset", 4'b0000, 1'b1, 1'b0);
        chk_g3("reset3", 3'b000);
        chk_s3("reset3", 3'b000, 1'b1, 1'b0);
        rstn = 1'b1;

        // Round robin with a response one cycle after each ack.
        req = 4'b1111; ack = 1'b1;
        for (int g = 0; g < 5; g++) begin
            tick();
            rsp_valid = 1'b0;
            chk_g4("rr_grant", 4'b0001 << (g % 4));
            chk_s4("rr_grant", 4'b0000, 1'b0, 1'b0);
            tick();
            chk_g4("rr_bubble", 4'b0000);
            chk_s4("rr_bubble", 4'b0000, 1'b0, 1'b0);
            rsp_valid = 1'b1; rsp_id = 2'(g % 4);
        end
        req = '0; ack = 1'b0;
        tick();
        rsp_valid = 1'b0;
        chk_g4("rr_end", 4'b0000);
        chk_s4("rr_end", 4'b0000, 1'b1, 1'b0);

        // Credit exhaustion on requester 0 (pointer now 1).
        req = 4'b0001; ack = 1'b1;
        tick(); chk_g4("cr_g1", 4'b0001);
        tick(); chk_g4("cr_b1", 4'b0000); chk_s4("cr_b1", 4'b0000, 1'b0, 1'b0);
        tick(); chk_g4("cr_g2", 4'b0001);
        tick(); chk_g4("cr_b2", 4'b0000); chk_s4("cr_full", 4'b0001, 1'b0, 1'b0);
        tick(); chk_g4("cr_blk1", 4'b0000);
        tick(); chk_g4("cr_blk2", 4'b0000);
        rsp_valid = 1'b1; rsp_id = 2'd0;
        tick();
        rsp_valid = 1'b0;
        chk_g4("cr_rsp", 4'b0000); chk_s4("cr_rsp", 4'b0000, 1'b0, 1'b0);
        tick(); chk_g4("cr_regrant", 4'b0001);
        req = '0; ack = 1'b0;
        tick(); chk_g4("cr_revoke", 4'b0000);
        rsp_valid = 1'b1; rsp_id = 2'd0;
        tick();
        rsp_valid = 1'b0;
        chk_s4("cr_drain", 4'b0000, 1'b1, 1'b0);

        // Held grant to 2, then ack moves on to 3 and wraps to 0.
        req = 4'b0100; ack = 1'b0;
        tick(); chk_g4("hold_g2", 4'b0100);
        req = 4'b1111;
        repeat (5) begin
            tick(); chk_g4("hold", 4'b0100);
        end
        ack = 1'b1;
        tick(); chk_g4("hold_ack", 4'b0000);
        tick(); chk_g4("hold_g3", 4'b1000);
        tick(); chk_g4("hold_ack3", 4'b0000);
        tick(); chk_g4("hold_wrap", 4'b0001);
        req = '0; ack = 1'b0;
        tick(); chk_g4("hold_rev", 4'b0000); chk_s4("hold_rev", 4'b0000, 1'b0, 1'b0);
        rsp_valid = 1'b1; rsp_id = 2'd2;
        tick();
        rsp_id = 2'd3;
        tick();
        rsp_valid = 1'b0;
        chk_s4("hold_drain", 4'b0000, 1'b1, 1'b0);

        // Revoke keeps pointer at 0: req 1010 must pick 1, not 3.
        req = 4'b0010;
        tick(); chk_g4("rv_g1", 4'b0010);
        req = 4'b0000;
        tick(); chk_g4("rv_drop", 4'b0000); chk_s4("rv_drop", 4'b0000, 1'b1, 1'b0);
        req = 4'b1010;
        tick(); chk_g4("rv_regrant", 4'b0010);
        req = 4'b0000;
        tick(); chk_g4("rv_drop2", 4'b0000);

        // Same-cycle ack and response on requester 2 nets to zero; then an illegal response.
        req = 4'b0100; ack = 1'b1;
        tick(); chk_g4("net_g2a", 4'b0100);
        tick(); chk_g4("net_b", 4'b0000);
        tick(); chk_g4("net_g2b", 4'b0100);
        rsp_valid = 1'b1; rsp_id = 2'd2;
        tick(); chk_g4("net_ack", 4'b0000); chk_s4("net_cnt1", 4'b0000, 1'b0, 1'b0);
        req = '0; ack = 1'b0; rsp_id = 2'd3;
        tick(); chk_g4("err_g", 4'b0000); chk_s4("err_pulse", 4'b0000, 1'b0, 1'b1);
        rsp_valid = 1'b0;
        tick(); chk_s4("err_clear", 4'b0000, 1'b0, 1'b0);
        rsp_valid = 1'b1; rsp_id = 2'd2;
        tick();
        rsp_valid = 1'b0;
        chk_s4("err_drain", 4'b0000, 1'b1, 1'b0);

        // N=3, MAX_OUT=1 instance.
        req3 = 3'b111; ack3 = 1'b1;
        tick(); chk_g3("n3_g0", 3'b001);
        tick(); chk_g3("n3_b0", 3'b000);
        tick(); chk_g3("n3_g1", 3'b010);
        tick(); chk_g3("n3_b1", 3'b000);
        tick(); chk_g3("n3_g2", 3'b100);
        tick(); chk_g3("n3_b2", 3'b000); chk_s3("n3_full", 3'b111, 1'b0, 1'b0);
        tick(); chk_g3("n3_blk", 3'b000); chk_s3("n3_blk", 3'b111, 1'b0, 1'b0);
        rsp_valid3 = 1'b1; rsp_id3 = 2'd0;
        tick();
        rsp_valid3 = 1'b0;
        chk_g3("n3_rsp", 3'b000); chk_s3("n3_rsp", 3'b110, 1'b0, 1'b0);
        tick(); chk_g3("n3_g0b", 3'b001);
        rstn = 1'b0;
        tick();
        rstn = 1'b1; req3 = '0; ack3 = 1'b0;
        chk_g3("n3_rst", 3'b000); chk_s3("n3_rst", 3'b000, 1'b1, 1'b0);
        chk_g4("n4_rst", 4'b0000);
        rsp_valid3 = 1'b1; rsp_id3 = 2'd3;
        tick();
        rsp_valid3 = 1'b0;
        chk_s3("n3_oob", 3'b000, 1'b1, 1'b1);
        tick(); chk_s3("n3_oob_clr", 3'b000, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
